// File: rtl/contour_point_streamer.sv
// contour_point_streamer: walks 8-connected strokes in the edge BRAM
// in raster order, streams their (x,y) points and clears each one.
module contour_point_streamer #(
  parameter int H_PIXELS     = 640,
  parameter int V_PIXELS     = 480,
  parameter int ADDR_W       = 19,
  parameter int READ_LATENCY = 2,
  parameter int MAX_POINTS   = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        target_code,
  input  logic [2:0]        bram_doutb,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [2:0]        bram_din,
  output logic              bram_we,
  output logic [9:0]        point_x,
  output logic [8:0]        point_y,
  output logic              point_first,
  output logic              point_valid,
  input  logic              point_ready,
  output logic [11:0]       num_points,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, SCAN_REQ, SCAN_WAIT, EMIT,
    CLEAR, NBR_REQ, NBR_WAIT, DONE
  } state_e;

  localparam int WW = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(H_PIXELS * V_PIXELS - 1);
  localparam logic [ADDR_W-1:0] HA = ADDR_W'(H_PIXELS);
  localparam logic [9:0]  XMAX  = 10'(H_PIXELS - 1);
  localparam logic [8:0]  YMAX  = 9'(V_PIXELS - 1);
  localparam logic [11:0] NMAX  = 12'(MAX_POINTS);
  localparam logic [WW-1:0] WLAST = WW'(READ_LATENCY);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] scan_a_q, scan_a_d;
  logic [9:0]        scan_x_q, scan_x_d;
  logic [8:0]        scan_y_q, scan_y_d;
  logic [ADDR_W-1:0] cur_a_q, cur_a_d;
  logic [9:0]        cur_x_q, cur_x_d;
  logic [8:0]        cur_y_q, cur_y_d;
  logic [ADDR_W-1:0] nbr_a_q, nbr_a_d;
  logic [9:0]        nbr_x_q, nbr_x_d;
  logic [8:0]        nbr_y_q, nbr_y_d;
  logic [2:0]        dir_q, dir_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              first_q, first_d;
  logic [11:0]       npts_q, npts_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              dxp, dxn, dyp, dyn;
  logic              nbr_ok, rd_match, adv;
  logic [ADDR_W-1:0] nbr_a;
  logic [9:0]        nbr_x;
  logic [8:0]        nbr_y;

  // Direction order E, SE, S, SW, W, NW, N, NE (y grows downward)
  always_comb begin
    dxp = 1'b0;
    dxn = 1'b0;
    dyp = 1'b0;
    dyn = 1'b0;
    unique case (dir_q)
      3'd0: dxp = 1'b1;
      3'd1: begin dxp = 1'b1; dyp = 1'b1; end
      3'd2: dyp = 1'b1;
      3'd3: begin dxn = 1'b1; dyp = 1'b1; end
      3'd4: dxn = 1'b1;
      3'd5: begin dxn = 1'b1; dyn = 1'b1; end
      3'd6: dyn = 1'b1;
      default: begin dxp = 1'b1; dyn = 1'b1; end
    endcase
  end

  assign nbr_ok = !(dxp && cur_x_q == XMAX)
               && !(dxn && cur_x_q == 10'd0)
               && !(dyp && cur_y_q == YMAX)
               && !(dyn && cur_y_q == 9'd0);
  assign nbr_x = cur_x_q + 10'(dxp) - 10'(dxn);
  assign nbr_y = cur_y_q + 9'(dyp) - 9'(dyn);
  assign nbr_a = cur_a_q + ADDR_W'(dxp) - ADDR_W'(dxn)
               + (dyp ? HA : '0) - (dyn ? HA : '0);

  assign rd_match = (target_code == 3'd0)
                  ? (bram_doutb != 3'd0)
                  : (bram_doutb == target_code);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      scan_a_q <= '0;
      scan_x_q <= '0;
      scan_y_q <= '0;
      cur_a_q  <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      nbr_a_q  <= '0;
      nbr_x_q  <= '0;
      nbr_y_q  <= '0;
      dir_q    <= '0;
      wcnt_q   <= '0;
      first_q  <= 1'b0;
      npts_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      scan_a_q <= scan_a_d;
      scan_x_q <= scan_x_d;
      scan_y_q <= scan_y_d;
      cur_a_q  <= cur_a_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      nbr_a_q  <= nbr_a_d;
      nbr_x_q  <= nbr_x_d;
      nbr_y_q  <= nbr_y_d;
      dir_q    <= dir_d;
      wcnt_q   <= wcnt_d;
      first_q  <= first_d;
      npts_q   <= npts_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    scan_a_d = scan_a_q;
    scan_x_d = scan_x_q;
    scan_y_d = scan_y_q;
    cur_a_d  = cur_a_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    nbr_a_d  = nbr_a_q;
    nbr_x_d  = nbr_x_q;
    nbr_y_d  = nbr_y_q;
    dir_d    = dir_q;
    wcnt_d   = wcnt_q;
    first_d  = first_q;
    npts_d   = npts_q;
    busy_d   = busy_q;
    done_d   = done_q;
    adv      = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d  = SCAN_REQ;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        npts_d   = '0;
        scan_a_d = '0;
        scan_x_d = '0;
        scan_y_d = '0;
      end
      SCAN_REQ: begin
        wcnt_d  = WW'(1);
        state_d = SCAN_WAIT;
      end
      SCAN_WAIT: if (wcnt_q == WLAST) begin
        if (rd_match) begin
          cur_a_d = scan_a_q;
          cur_x_d = scan_x_q;
          cur_y_d = scan_y_q;
          first_d = 1'b1;
          state_d = EMIT;
        end else begin
          adv = 1'b1;
        end
      end else begin
        wcnt_d = wcnt_q + WW'(1);
      end
      EMIT: if (point_ready) begin
        if (npts_q != NMAX) npts_d = npts_q + 12'd1;
        state_d = CLEAR;
      end
      CLEAR: begin
        first_d = 1'b0;
        dir_d   = 3'd0;
        state_d = NBR_REQ;
      end
      NBR_REQ: if (nbr_ok) begin
        nbr_a_d = nbr_a;
        nbr_x_d = nbr_x;
        nbr_y_d = nbr_y;
        wcnt_d  = WW'(1);
        state_d = NBR_WAIT;
      end else if (dir_q == 3'd7) begin
        adv = 1'b1;
      end else begin
        dir_d = dir_q + 3'd1;
      end
      NBR_WAIT: if (wcnt_q == WLAST) begin
        if (rd_match) begin
          cur_a_d = nbr_a_q;
          cur_x_d = nbr_x_q;
          cur_y_d = nbr_y_q;
          state_d = EMIT;
        end else if (dir_q == 3'd7) begin
          adv = 1'b1;
        end else begin
          dir_d   = dir_q + 3'd1;
          state_d = NBR_REQ;
        end
      end else begin
        wcnt_d = wcnt_q + WW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Resume the raster scan just past where the stroke began
    if (adv) begin
      if (scan_a_q == LAST) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        scan_a_d = scan_a_q + ADDR_W'(1);
        if (scan_x_q == XMAX) begin
          scan_x_d = '0;
          scan_y_d = scan_y_q + 9'd1;
        end else begin
          scan_x_d = scan_x_q + 10'd1;
        end
        state_d = SCAN_REQ;
      end
    end
  end

  always_comb begin
    bram_addrb = scan_a_q;
    if (state_q == NBR_REQ)
      bram_addrb = nbr_ok ? nbr_a : nbr_a_q;
    else if (state_q == NBR_WAIT)
      bram_addrb = nbr_a_q;
    bram_addr   = cur_a_q;
    bram_din    = 3'd0;
    bram_we     = (state_q == CLEAR);
    point_x     = cur_x_q;
    point_y     = cur_y_q;
    point_valid = (state_q == EMIT);
    point_first = first_q && (state_q == EMIT);
    num_points  = npts_q;
    busy        = busy_q;
    done        = done_q;
  end

endmodule
